vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between two requesters: the CPU side (native interface driven by the AXI-lite slave FSM) and the VGA scanout.
- CPU accesses have absolute priority and fixed latency.
- Scanout reads are prefetched into a small FIFO so CPU stalls never starve the pixel pipeline.
- Sits between the AXI-lite slave, the framebuffer RAM and the VGA timing/pixel generator.

---
 rtl/vga_axil_pkg.sv | 25 ++
 rtl/vga_fb_arbiter_if.sv | 42 ++++
 rtl/vga_sync_fifo.sv | 67 ++++++
 rtl/vga_fb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_axil_pkg.sv
// rtl/vga_axil_pkg.sv - shared types for the VGA framebuffer path
package vga_axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int FB_ADDR_W   = 16;

    typedef logic [AXIL_DATA_W-1:0] axil_data_t;
    typedef logic [FB_ADDR_W-1:0]   fb_addr_t;
    typedef axil_data_t             fb_data_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_FLUSH
    } fetch_state_e;

    typedef enum logic [2:0] {
        GntNone,
        GntCpuRd,
        GntCpuWrBuf,
        GntCpuWr,
        GntFetch
    } grant_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - CPU, scanout and RAM signals of the framebuffer arbiter
interface vga_fb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              cpu_write_en;
    logic [ADDR_W-1:0] cpu_addr_write;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_read_en;
    logic [ADDR_W-1:0] cpu_addr_read;
    logic [DATA_W-1:0] cpu_rdata;
    logic              frame_start;
    logic              pix_ready;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              underflow;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_write_en, cpu_addr_write, cpu_wdata,
        input  cpu_read_en, cpu_addr_read,
        output cpu_rdata,
        input  frame_start, pix_ready,
        output pix_valid, pix_data, underflow,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_write_en, cpu_addr_write, cpu_wdata,
        output cpu_read_en, cpu_addr_read,
        input  cpu_rdata,
        output frame_start, pix_ready,
        input  pix_valid, pix_data, underflow,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vga_sync_fifo.sv
// rtl/vga_sync_fifo.sv - show-ahead synchronous FIFO with flush
module vga_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    // Head word is forced to zero while empty so the output is defined from reset
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM shared by CPU and VGA scanout prefetch
module vga_fb_arbiter
    import vga_axil_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int FB_DEPTH   = 19200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            arst,
    vga_fb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    grant_e            gnt;
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q, inflight_d;
    logic              rd_pending_q, rd_pending_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
    logic              wbuf_valid_q, wbuf_valid_d;
    logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [DATA_W-1:0] wbuf_data_q, wbuf_data_d;
    logic              underflow_q, underflow_d;

    logic              fetch_ok;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_dout;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Credit counts in-flight returns so a push can never meet a full FIFO
    assign fetch_ok = (state_q != FETCH_IDLE) &&
                      ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);

    always_comb begin
        gnt = GntNone;
        if (bus.cpu_read_en)       gnt = GntCpuRd;
        else if (wbuf_valid_q)     gnt = GntCpuWrBuf;
        else if (bus.cpu_write_en) gnt = GntCpuWr;
        else if (fetch_ok)         gnt = GntFetch;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GntCpuRd: begin
                mem_en   = 1'b1;
                mem_addr = bus.cpu_addr_read;
            end
            GntCpuWrBuf: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wbuf_addr_q;
                mem_wdata = wbuf_data_q;
            end
            GntCpuWr: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = bus.cpu_addr_write;
                mem_wdata = bus.cpu_wdata;
            end
            GntFetch: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        if (bus.frame_start) begin
            state_d      = FETCH_FLUSH;
            fetch_addr_d = '0;
        end else begin
            case (state_q)
                FETCH_FLUSH: state_d = FETCH_RUN;
                default:     state_d = state_q;
            endcase
            if (gnt == GntFetch)
                fetch_addr_d = (fetch_addr_q == ADDR_W'(FB_DEPTH - 1)) ? '0
                                                                       : fetch_addr_q + ADDR_W'(1);
        end
        // A fetch issued alongside frame_start belongs to the old frame; drop its tag
        inflight_d   = (gnt == GntFetch) && !bus.frame_start;
        rd_pending_d = (gnt == GntCpuRd);
        rdata_hold_d = rd_pending_q ? bus.mem_rdata : rdata_hold_q;

        wbuf_valid_d = wbuf_valid_q && (gnt != GntCpuWrBuf);
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_data_d  = wbuf_data_q;
        if (bus.cpu_write_en && bus.cpu_read_en) begin
            wbuf_valid_d = 1'b1;
            wbuf_addr_d  = bus.cpu_addr_write;
            wbuf_data_d  = bus.cpu_wdata;
        end
        underflow_d = underflow_q || (bus.pix_ready && fifo_empty);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= FETCH_IDLE;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            rdata_hold_q <= '0;
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            rd_pending_q <= rd_pending_d;
            rdata_hold_q <= rdata_hold_d;
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_data_q  <= wbuf_data_d;
            underflow_q  <= underflow_d;
            assert (!(bus.cpu_write_en && wbuf_valid_q))
                else $error("vga_fb_arbiter: write strobe while write buffer full");
            assert (!(inflight_q && fifo_full && !bus.pix_ready && !bus.frame_start))
                else $error("vga_fb_arbiter: prefetch push into full FIFO");
        end
    end

    vga_sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .arst (arst),
        .flush(bus.frame_start),
        .push (inflight_q),
        .din  (bus.mem_rdata),
        .pop  (bus.pix_ready),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_rdata = rd_pending_q ? bus.mem_rdata : rdata_hold_q;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_dout;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.DATA_W(32), .ADDR_W(16)) b  ();
    vga_fb_arbiter_if #(.DATA_W(32), .ADDR_W(16)) b4 ();

    vga_fb_arbiter #(.DATA_W(32), .ADDR_W(16), .FB_DEPTH(19200), .FIFO_DEPTH(8)) u_dut (
        .clk (clk),
        .arst(arst),
        .bus (b)
    );

    vga_fb_arbiter #(.DATA_W(32), .ADDR_W(16), .FB_DEPTH(4), .FIFO_DEPTH(8)) u_dut4 (
        .clk (clk),
        .arst(arst),
        .bus (b4)
    );

    logic [31:0] ram  [65536];
    logic [31:0] ram4 [16];

    always @(posedge clk) begin
        if (b.mem_en) begin
            if (b.mem_we) ram[b.mem_addr] <= b.mem_wdata;
            else          b.mem_rdata     <= ram[b.mem_addr];
        end
        if (b4.mem_en) begin
            if (b4.mem_we) ram4[b4.mem_addr[3:0]] <= b4.mem_wdata;
            else           b4.mem_rdata           <= ram4[b4.mem_addr[3:0]];
        end
    end

    function automatic logic [31:0] w(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] w4(input int a);
        return 32'hB000_0000 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_mem_en"},    32'(b.mem_en),    32'h0);
        chk({pfx, "_mem_we"},    32'(b.mem_we),    32'h0);
        chk({pfx, "_mem_addr"},  32'(b.mem_addr),  32'h0);
        chk({pfx, "_mem_wdata"}, b.mem_wdata,      32'h0);
        chk({pfx, "_cpu_rdata"}, b.cpu_rdata,      32'h0);
        chk({pfx, "_pix_valid"}, 32'(b.pix_valid), 32'h0);
        chk({pfx, "_pix_data"},  b.pix_data,       32'h0);
        chk({pfx, "_underflow"}, 32'(b.underflow), 32'h0);
    endtask

    initial begin
        b.cpu_write_en  = 1'b0; b.cpu_addr_write  = '0; b.cpu_wdata  = '0;
        b.cpu_read_en   = 1'b0; b.cpu_addr_read   = '0;
        b.frame_start   = 1'b0; b.pix_ready       = 1'b0;
        b4.cpu_write_en = 1'b0; b4.cpu_addr_write = '0; b4.cpu_wdata = '0;
        b4.cpu_read_en  = 1'b0; b4.cpu_addr_read  = '0;
        b4.frame_start  = 1'b0; b4.pix_ready      = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = w(i);
        ram[16'h0040] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) ram4[i] = w4(i);

        // Reset state
        cyc(3);
        chk_reset("rst");
        chk("rst4_cpu_rdata", b4.cpu_rdata, 32'h0);
        arst = 1'b0;
        cyc(2);
        chk("idle_no_fetch", 32'(b.mem_en), 32'h0);

        // Frame start with idle CPU: prefetch words 0..7, then stop
        b.frame_start = 1'b1; #1;
        chk("fs_cycle_no_fetch", 32'(b.mem_en), 32'h0);
        cyc(); b.frame_start = 1'b0; #1;
        chk("flush_fetch_en", 32'(b.mem_en), 32'h1);
        chk("flush_fetch_addr", 32'(b.mem_addr), 32'h0);
        chk("flush_pix_valid", 32'(b.pix_valid), 32'h0);
        cyc();
        chk("e1_pix_valid", 32'(b.pix_valid), 32'h0);
        chk("e1_fetch_addr", 32'(b.mem_addr), 32'h1);
        cyc();
        chk("e2_pix_valid", 32'(b.pix_valid), 32'h1);
        chk("e2_pix_data", b.pix_data, w(0));
        chk("e2_fetch_addr", 32'(b.mem_addr), 32'h2);
        for (int k = 3; k <= 7; k++) begin
            cyc();
            chk($sformatf("fetch_addr_%0d", k), 32'(b.mem_addr), 32'(k));
        end
        cyc();
        chk("fetch_stop_credit", 32'(b.mem_en), 32'h0);
        cyc();
        chk("full_pix_valid", 32'(b.pix_valid), 32'h1);
        chk("full_pix_data", b.pix_data, w(0));
        chk("full_no_fetch", 32'(b.mem_en), 32'h0);

        // CPU read preempts scanout; fetch resumes at the next address
        b.pix_ready = 1'b1; #1;
        chk("head_before_pop", b.pix_data, w(0));
        cyc(); b.pix_ready = 1'b0; b.cpu_read_en = 1'b1; b.cpu_addr_read = 16'h0040; #1;
        chk("cpurd_mem_addr", 32'(b.mem_addr), 32'h40);
        chk("cpurd_mem_we", 32'(b.mem_we), 32'h0);
        chk("cpurd_mem_en", 32'(b.mem_en), 32'h1);
        cyc(); b.cpu_read_en = 1'b0; #1;
        chk("cpurd_rdata", b.cpu_rdata, 32'hDEAD_BEEF);
        chk("fetch_resume_addr", 32'(b.mem_addr), 32'h8);
        chk("fetch_resume_en", 32'(b.mem_en), 32'h1);
        cyc();
        chk("cpurd_rdata_held", b.cpu_rdata, 32'hDEAD_BEEF);
        b.pix_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("pop_seq_%0d", k), b.pix_data, w(k));
            cyc();
        end
        b.pix_ready = 1'b0;

        // Coincident write and read: read first, buffered write next cycle
        b.cpu_write_en = 1'b1; b.cpu_addr_write = 16'h0010; b.cpu_wdata = 32'h1234_5678;
        b.cpu_read_en  = 1'b1; b.cpu_addr_read  = 16'h0020; #1;
        chk("coinc_rd_addr", 32'(b.mem_addr), 32'h20);
        chk("coinc_rd_we", 32'(b.mem_we), 32'h0);
        cyc(); b.cpu_write_en = 1'b0; b.cpu_read_en = 1'b0; #1;
        chk("wbuf_we", 32'(b.mem_we), 32'h1);
        chk("wbuf_addr", 32'(b.mem_addr), 32'h10);
        chk("wbuf_wdata", b.mem_wdata, 32'h1234_5678);
        chk("coinc_rdata", b.cpu_rdata, w(32'h20));
        cyc(); b.cpu_read_en = 1'b1; b.cpu_addr_read = 16'h0010; #1;
        chk("readback_addr", 32'(b.mem_addr), 32'h10);
        cyc(); b.cpu_read_en = 1'b0; #1;
        chk("readback_rdata", b.cpu_rdata, 32'h1234_5678);
        chk("no_underflow", 32'(b.underflow), 32'h0);

        // Frame start with a fetch in flight and five words buffered
        cyc(6);
        b.pix_ready = 1'b1; b.cpu_read_en = 1'b1; b.cpu_addr_read = 16'h0040;
        cyc(3);
        b.pix_ready = 1'b0; b.cpu_read_en = 1'b0;
        cyc();
        b.frame_start = 1'b1; #1;
        chk("pre_flush_valid", 32'(b.pix_valid), 32'h1);
        chk("fetch_in_fs_cycle", 32'(b.mem_en), 32'h1);
        cyc(); b.frame_start = 1'b0; #1;
        chk("flush_empties", 32'(b.pix_valid), 32'h0);
        chk("flush_refetch_addr", 32'(b.mem_addr), 32'h0);
        cyc();
        chk("stale_dropped", 32'(b.pix_valid), 32'h0);
        cyc();
        chk("refill_valid", 32'(b.pix_valid), 32'h1);
        chk("refill_data", b.pix_data, w(0));

        // FB_DEPTH=4 instance: continuous pop shows the scanout address wrap
        b4.frame_start = 1'b1;
        cyc(); b4.frame_start = 1'b0;
        cyc(3);
        b4.pix_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("wrap_seq_%0d", k), b4.pix_data, w4(k % 4));
            cyc();
        end
        b4.pix_ready = 1'b0;
        chk("wrap_no_underflow", 32'(b4.underflow), 32'h0);

        // Underflow before any frame start is sticky until arst
        arst = 1'b1; cyc(); arst = 1'b0; cyc();
        b.pix_ready = 1'b1;
        cyc(); b.pix_ready = 1'b0; #1;
        chk("underflow_set", 32'(b.underflow), 32'h1);
        cyc(3);
        chk("underflow_sticky", 32'(b.underflow), 32'h1);
        b.frame_start = 1'b1;
        cyc(); b.frame_start = 1'b0;
        cyc(4);
        chk("uf_run_valid", 32'(b.pix_valid), 32'h1);
        chk("uf_run_sticky", 32'(b.underflow), 32'h1);
        b.cpu_read_en = 1'b1; b.cpu_addr_read = 16'h0040;
        cyc(); b.cpu_read_en = 1'b0; #1;
        chk("pre_arst_rdata", b.cpu_rdata, 32'hDEAD_BEEF);
        cyc();
        arst = 1'b1; #1;
        chk_reset("arst");
        cyc(); arst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
